apu_div_dispatch: RTL and testbench

Request-side dispatcher for the shared iterative integer divider of the APU cluster. Accepts division/remainder requests from NCORES cores and arbitrates them round-robin. Issues one operation at a time over the unit's En/Ready/Valid/Tag interface and routes each result back to the originating core. It sits between the core-side APU ports and the single `int_div` instance.

---
 rtl/apu_package.sv | 28 ++
 rtl/apu_rr_arbiter.sv | 55 +++++
 rtl/apu_div_dispatch.sv | 177 +++++++++++++++++
 tb/tb_apu_div_dispatch.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/apu_package.sv
// Shared APU definitions: dispatcher FSM states, timeout limit, tag-width relations.
// Latency: n/a (types, constants and elaboration-time helpers only).
// Backpressure: n/a.
package apu_package;

  // Dispatcher FSM states; DRAIN is only reachable when the timeout feature is built in.
  typedef enum logic [1:0] {
    DISP_IDLE  = 2'd0,
    DISP_BUSY  = 2'd1,
    DISP_DRAIN = 2'd2
  } apu_div_disp_state_e;

  // BUSY cycles allowed before a granted core is answered with an error.
  localparam int unsigned APU_DIV_TIMEOUT = 63;
  localparam int unsigned APU_DIV_CNT_W   = 6;

  // Core index width; one core still carries a 1-bit (tied 0) index field.
  function automatic int unsigned apu_idx_width(input int unsigned ncores);
    return (ncores > 1) ? $clog2(ncores) : 1;
  endfunction

  // Unit-side tag = {core index, core tag}.
  function automatic int unsigned apu_unit_tag_width(input int unsigned tag_w,
                                                     input int unsigned ncores);
    return tag_w + apu_idx_width(ncores);
  endfunction

endpackage

// File: rtl/apu_rr_arbiter.sv
// Round-robin arbiter: one-hot grant and index of the first requester at or after the pointer.
// Latency: combinational grant; pointer moves past the winner on the clock after a grant.
// Backpressure: en_i low suppresses the grant and freezes the pointer.
module apu_rr_arbiter
  import apu_package::*;
#(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = apu_idx_width(N)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [N-1:0]     req_i,
  input  logic             en_i,
  output logic [N-1:0]     gnt_o,
  output logic [IDX_W-1:0] idx_o
);

  logic [IDX_W-1:0] r_ptr;
  logic             w_found;
  logic [IDX_W-1:0] w_idx;

  // Search the requests starting at the pointer, wrapping modulo N.
  always_comb begin : p_search
    int unsigned v_cand;
    v_cand  = 0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      v_cand = 32'(r_ptr) + i;
      if (v_cand >= N) v_cand = v_cand - N;
      if (!w_found && req_i[v_cand]) begin
        w_found = 1'b1;
        w_idx   = IDX_W'(v_cand);
      end
    end
  end

  // One-hot grant only while enabled.
  always_comb begin
    gnt_o = '0;
    if (en_i && w_found) gnt_o[w_idx] = 1'b1;
  end

  assign idx_o = w_idx;

  // Pointer moves to the slot after the winner; holds when nothing is granted.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_ptr <= '0;
    end else if (en_i && w_found) begin
      r_ptr <= IDX_W'((32'(w_idx) + 1) % N);
    end
  end

endmodule

// File: rtl/apu_div_dispatch.sv
// Dispatcher for the shared divider: RR-grants one core request at a time, routes result back.
// Latency: grant/start combinational in IDLE; result reaches the core 1 cycle after unit valid.
// Backpressure: no grant while unit_ready_i=0 or an op is in flight; optional timeout via APU_DIV_DISP_TIMEOUT_EN.
module apu_div_dispatch
  import apu_package::*;
#(
  parameter int unsigned NCORES    = 4,
  parameter int unsigned TAG_WIDTH = 5,
  parameter int unsigned IDX_W     = apu_idx_width(NCORES)
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic [NCORES-1:0]                  core_req_i,
  output logic [NCORES-1:0]                  core_gnt_o,
  input  logic [NCORES-1:0][2:0]             core_op_i,
  input  logic [NCORES-1:0][31:0]            core_opa_i,
  input  logic [NCORES-1:0][31:0]            core_opb_i,
  input  logic [NCORES-1:0][TAG_WIDTH-1:0]   core_tag_i,
  output logic [NCORES-1:0]                  core_rvalid_o,
  output logic [31:0]                        core_rdata_o,
  output logic [TAG_WIDTH-1:0]               core_rtag_o,
  output logic                               core_rerr_o,
  output logic                               unit_en_o,
  output logic [2:0]                         unit_op_o,
  output logic [31:0]                        unit_opa_o,
  output logic [31:0]                        unit_opb_o,
  output logic [TAG_WIDTH+IDX_W-1:0]         unit_tag_o,
  input  logic                               unit_ready_i,
  input  logic                               unit_valid_i,
  input  logic [31:0]                        unit_res_i,
  input  logic [TAG_WIDTH+IDX_W-1:0]         unit_tag_i
);

  apu_div_disp_state_e r_state, w_next_state;

  logic                 w_arb_en;
  logic [NCORES-1:0]    w_gnt;
  logic [IDX_W-1:0]     w_idx;
  logic                 w_grant;
  logic [IDX_W-1:0]     w_res_idx;
  logic [TAG_WIDTH-1:0] w_res_tag;
  logic                 w_res_take;
  logic                 w_timeout;
  logic [IDX_W-1:0]     w_to_idx;
  logic [TAG_WIDTH-1:0] w_to_tag;

  logic [NCORES-1:0]    r_rvalid;
  logic [31:0]          r_rdata;
  logic [TAG_WIDTH-1:0] r_rtag;

  // Gating with rst_ni keeps grant and start low while reset is held, even with requests pending.
  assign w_arb_en   = rst_ni && (r_state == DISP_IDLE) && unit_ready_i;
  assign w_grant    = |w_gnt;
  assign w_res_idx  = unit_tag_i[TAG_WIDTH +: IDX_W];
  assign w_res_tag  = unit_tag_i[TAG_WIDTH-1:0];
  assign w_res_take = (r_state == DISP_BUSY) && unit_valid_i;

  apu_rr_arbiter #(
    .N     (NCORES),
    .IDX_W (IDX_W)
  ) u_arb (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .req_i  (core_req_i),
    .en_i   (w_arb_en),
    .gnt_o  (w_gnt),
    .idx_o  (w_idx)
  );

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= DISP_IDLE;
    else         r_state <= w_next_state;
  end

  // Next state: a valid in BUSY always wins over a same-cycle timeout.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      DISP_IDLE:  if (w_grant) w_next_state = DISP_BUSY;
      DISP_BUSY: begin
        if (unit_valid_i)   w_next_state = DISP_IDLE;
        else if (w_timeout) w_next_state = DISP_DRAIN;
      end
`ifdef APU_DIV_DISP_TIMEOUT_EN
      DISP_DRAIN: if (unit_valid_i) w_next_state = DISP_IDLE;
`endif
      default:    w_next_state = DISP_IDLE;
    endcase
  end

  // Grant-cycle outputs: forward the winner's operation, zero otherwise.
  always_comb begin
    core_gnt_o = w_gnt;
    unit_en_o  = w_grant;
    unit_op_o  = '0;
    unit_opa_o = '0;
    unit_opb_o = '0;
    unit_tag_o = '0;
    if (w_grant) begin
      unit_op_o  = core_op_i[w_idx];
      unit_opa_o = core_opa_i[w_idx];
      unit_opb_o = core_opb_i[w_idx];
      unit_tag_o = {w_idx, core_tag_i[w_idx]};
    end
  end

`ifdef APU_DIV_DISP_TIMEOUT_EN
  localparam logic [APU_DIV_CNT_W-1:0] L_TIMEOUT = APU_DIV_CNT_W'(APU_DIV_TIMEOUT);

  logic [APU_DIV_CNT_W-1:0] r_cnt;
  logic [APU_DIV_CNT_W-1:0] w_cnt_inc;
  logic [IDX_W-1:0]         r_gidx;
  logic [TAG_WIDTH-1:0]     r_gtag;
  logic                     r_rerr;

  // w_cnt_inc counts BUSY cycles including the current one.
  assign w_cnt_inc = r_cnt + APU_DIV_CNT_W'(1);
  assign w_timeout = (r_state == DISP_BUSY) && !unit_valid_i && (w_cnt_inc == L_TIMEOUT);
  assign w_to_idx  = r_gidx;
  assign w_to_tag  = r_gtag;

  // Remember who was granted and count BUSY cycles for the timeout.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt  <= '0;
      r_gidx <= '0;
      r_gtag <= '0;
    end else if (w_grant) begin
      r_cnt  <= '0;
      r_gidx <= w_idx;
      r_gtag <= core_tag_i[w_idx];
    end else if (r_state == DISP_BUSY) begin
      r_cnt  <= w_cnt_inc;
    end
  end

  // Error flag accompanies the timeout strobe and is cleared by a real result.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)         r_rerr <= 1'b0;
    else if (w_res_take) r_rerr <= 1'b0;
    else if (w_timeout)  r_rerr <= 1'b1;
  end

  assign core_rerr_o = r_rerr;
`else
  assign w_timeout   = 1'b0;
  assign w_to_idx    = '0;
  assign w_to_tag    = '0;
  assign core_rerr_o = 1'b0;
`endif

  // Result return: one-cycle strobe to the owning core, data/tag held between strobes.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rvalid <= '0;
      r_rdata  <= '0;
      r_rtag   <= '0;
    end else begin
      r_rvalid <= '0;
      if (w_res_take) begin
        r_rvalid <= NCORES'(1) << w_res_idx;
        r_rdata  <= unit_res_i;
        r_rtag   <= w_res_tag;
      end else if (w_timeout) begin
        r_rvalid <= NCORES'(1) << w_to_idx;
        r_rdata  <= 32'hFFFF_FFFF;
        r_rtag   <= w_to_tag;
      end
    end
  end

  assign core_rvalid_o = r_rvalid;
  assign core_rdata_o  = r_rdata;
  assign core_rtag_o   = r_rtag;

endmodule

// File: tb/tb_apu_div_dispatch.sv
// Randomized bench for apu_div_dispatch with a behavioural divider unit and a reference dispatcher model.
// Latency: checks grant-cycle outputs and the one-cycle result return against the model each cycle.
// Backpressure: unit ready/valid driven by the unit model; APU_DIV_DISP_TIMEOUT_EN adds the hang scenario.
module tb_apu_div_dispatch;
  localparam int NC = 4;
  localparam int TW = 5;
  localparam int IW = 2;
  localparam int UW = TW + IW;
  localparam logic [2:0] OP_DIV = 3'd0, OP_DIVU = 3'd1, OP_REM = 3'd2, OP_REMU = 3'd3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NC-1:0]         req;
  logic [NC-1:0][2:0]    op;
  logic [NC-1:0][31:0]   opa, opb;
  logic [NC-1:0][TW-1:0] tag;
  logic [NC-1:0]         gnt, rvalid;
  logic [31:0]           rdata;
  logic [TW-1:0]         rtag;
  logic                  rerr, u_en;
  logic [2:0]            u_op;
  logic [31:0]           u_opa, u_opb;
  logic [UW-1:0]         u_tago;
  logic                  u_ready, u_valid;
  logic [31:0]           u_res;
  logic [UW-1:0]         u_tagi;

  always #5 clk = ~clk;

  apu_div_dispatch #(.NCORES(NC), .TAG_WIDTH(TW)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .core_req_i(req), .core_gnt_o(gnt), .core_op_i(op), .core_opa_i(opa), .core_opb_i(opb),
    .core_tag_i(tag), .core_rvalid_o(rvalid), .core_rdata_o(rdata), .core_rtag_o(rtag),
    .core_rerr_o(rerr), .unit_en_o(u_en), .unit_op_o(u_op), .unit_opa_o(u_opa),
    .unit_opb_o(u_opb), .unit_tag_o(u_tago), .unit_ready_i(u_ready), .unit_valid_i(u_valid),
    .unit_res_i(u_res), .unit_tag_i(u_tagi)
  );

  int n_tests = 0, n_fail = 0, cyc = 0;
  // behavioural divider unit
  bit um_active = 0, um_hang = 0;
  int um_cnt = 0, um_lat = 4;
  logic [31:0] um_res;
  logic [UW-1:0] um_tag;
  // reference dispatcher model
  bit m_busy = 0, m_drain = 0;
  int m_ptr = 0, m_tcnt = 0, m_core = 0;
  logic [TW-1:0] m_tag;
  logic [31:0] m_exp;
  logic [NC-1:0] m_rv = '0;
  logic [31:0] m_rv_dat;
  logic [TW-1:0] m_rv_tag;
  bit m_rv_err;
  bit cont [NC];
  int hist[$];
  int g_cyc = 0, rv_cyc = -1, n;
  logic [31:0] last_rdata;
  logic [TW-1:0] last_rtag;
  logic last_rerr;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // RISC-V M-extension division semantics.
  function automatic logic [31:0] refdiv(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    bit ovf;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (o)
      OP_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      OP_REMU: return (b == 0) ? a : a % b;
      OP_DIV:  return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'($signed(a) / $signed(b));
      OP_REM:  return (b == 0) ? a : ovf ? 32'h0 : 32'($signed(a) % $signed(b));
      default: return 32'h0;
    endcase
  endfunction

  task automatic set_req(input int c, input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [TW-1:0] t);
    op[c] = o; opa[c] = a; opb[c] = b; tag[c] = t; req[c] = 1'b1;
  endtask

  // One clock: check at negedge, advance models, update unit and requests after posedge.
  task automatic cycle();
    logic [NC-1:0] e_gnt, drop;
    int k;
    bit s_en;
    logic [2:0] s_op;
    logic [31:0] s_opa, s_opb;
    logic [UW-1:0] s_tag;
    @(negedge clk);
    e_gnt = '0; drop = '0; k = -1;
    if (rst_n && !m_busy && u_ready)
      for (int i = 0; i < NC; i++)
        if (k < 0 && req[(m_ptr + i) % NC]) k = (m_ptr + i) % NC;
    if (k >= 0) e_gnt[k] = 1'b1;
    chk("gnt", gnt, e_gnt);
    chk("unit_en", u_en, (k >= 0));
    if (k >= 0) begin
      chk("unit_tag", u_tago, {k[IW-1:0], tag[k]});
      chk("unit_opnd", {u_op, u_opa, u_opb}, {op[k], opa[k], opb[k]});
    end else begin
      chk("unit_idle_out", {u_op, u_opa, u_opb, u_tago}, 0);
    end
    chk("rvalid", rvalid, m_rv);
    if (!rst_n) chk("rst_result", {rdata, rtag, rerr}, 0);
    if (m_rv != 0) begin
      chk("rdata", rdata, m_rv_dat);
      chk("rtag", rtag, m_rv_tag);
      chk("rerr", rerr, m_rv_err);
      rv_cyc = cyc; last_rdata = rdata; last_rtag = rtag; last_rerr = rerr;
    end
    m_rv = '0;
    if (rst_n && m_busy) begin
      if (u_valid) begin
        if (!m_drain) begin
          m_rv = NC'(1) << m_core; m_rv_dat = m_exp; m_rv_tag = m_tag; m_rv_err = 0;
        end
        m_busy = 0; m_drain = 0;
      end else if (!m_drain) begin
        m_tcnt++;
`ifdef APU_DIV_DISP_TIMEOUT_EN
        if (m_tcnt == 63) begin
          m_rv = NC'(1) << m_core; m_rv_dat = 32'hFFFF_FFFF; m_rv_tag = m_tag; m_rv_err = 1;
          m_drain = 1;
        end
`endif
      end
    end
    if (k >= 0) begin
      m_busy = 1; m_tcnt = 0; m_core = k; m_tag = tag[k];
      m_exp = refdiv(op[k], opa[k], opb[k]);
      m_ptr = (k + 1) % NC; hist.push_back(k); g_cyc = cyc;
      if (!cont[k]) drop[k] = 1'b1;
    end
    s_en = u_en; s_op = u_op; s_opa = u_opa; s_opb = u_opb; s_tag = u_tago;
    @(posedge clk); #1; cyc++;
    if (u_valid) begin u_valid = 0; um_active = 0; end
    if (s_en) begin
      um_active = 1; um_tag = s_tag; um_res = refdiv(s_op, s_opa, s_opb); um_cnt = um_lat;
    end
    if (um_active && !um_hang && um_cnt > 0) begin
      um_cnt--;
      if (um_cnt == 0) begin u_valid = 1; u_res = um_res; u_tagi = um_tag; end
    end
    req = req & ~drop;
    u_ready = !um_active;
  endtask

  task automatic do_reset(input int cycles);
    rst_n = 0;
    m_busy = 0; m_drain = 0; m_ptr = 0; m_rv = '0;
    um_active = 0; um_cnt = 0; u_valid = 0; u_ready = 1;
    repeat (cycles) cycle();
    rst_n = 1;
  endtask

  task automatic run_until_quiet(input int budget, input string name);
    int c;
    c = 0;
    while ((req != 0 || m_busy || m_rv != 0 || um_active) && c < budget) begin
      cycle(); c++;
    end
    chk(name, (c >= budget), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    req = '0; op = '0; opa = '0; opb = '0; tag = '0;
    u_ready = 1; u_valid = 0; u_res = '0; u_tagi = '0;
    for (int i = 0; i < NC; i++) cont[i] = 0;
    @(posedge clk); #1;
    do_reset(3);

    // single request: core 2 DIVU 100/7 tag 5, latency 34
    um_lat = 34; rv_cyc = -1; hist.delete();
    set_req(2, OP_DIVU, 32'd100, 32'd7, 5'd5);
    run_until_quiet(100, "single_budget");
    chk("single_core", hist[0], 2);
    chk("single_lat", rv_cyc - g_cyc, 35);
    chk("single_rdata", last_rdata, 32'd14);
    chk("single_rtag", last_rtag, 5'd5);

    // all four after reset: served in order 0..3
    do_reset(2);
    hist.delete(); um_lat = 3;
    for (int c = 0; c < NC; c++) set_req(c, OP_DIV, 32'(-100 - c), 32'd3, TW'(c + 8));
    run_until_quiet(100, "all4_budget");
    chk("all4_cnt", hist.size(), 4);
    for (int c = 0; c < 4 && c < hist.size(); c++) chk("all4_order", hist[c], c);

    // continuous core 1 vs one-shot core 3
    hist.delete(); um_lat = 2; cont[1] = 1;
    set_req(1, OP_REMU, 32'd77, 32'd10, 5'd1);
    set_req(3, OP_REM, 32'hFFFF_FF00, 32'd7, 5'd3);
    n = 0;
    while (hist.size() < 3 && n < 100) begin cycle(); n++; end
    chk("rr_budget", (n >= 100), 0);
    cont[1] = 0; req[1] = 1'b0;
    run_until_quiet(50, "rr_drain");
    chk("rr_first", hist[0], 1);
    chk("rr_fair", hist[1], 3);
    chk("rr_again", hist[2], 1);

    // spurious unit valid while idle
    hist.delete();
    u_valid = 1; u_res = 32'h1234; u_tagi = {2'd1, 5'd3};
    cycle(); cycle();
    set_req(0, OP_DIVU, 32'd9, 32'd2, 5'd4);
    cycle();
    chk("spur_then_grant", hist.size(), 1);
    run_until_quiet(50, "spur_budget");

    // reset while busy; pending request granted after release
    hist.delete(); um_lat = 20;
    set_req(0, OP_DIVU, 32'd1000, 32'd10, 5'd2);
    repeat (5) cycle();
    set_req(2, OP_DIV, 32'd64, 32'd8, 5'd6);
    do_reset(2);
    run_until_quiet(100, "rst_budget");
    chk("rst_hist", hist.size(), 2);
    chk("rst_regrant", hist[$], 2);

    // randomized traffic
    for (int it = 0; it < 800; it++) begin
      um_lat = $urandom_range(1, 8);
      for (int c = 0; c < NC; c++)
        if (!req[c] && $urandom_range(0, 3) == 0)
          set_req(c, 3'($urandom_range(0, 7)), $urandom,
                  ($urandom_range(0, 5) == 0) ? 32'h0 : 32'($urandom_range(0, 1000)), TW'($urandom));
      if (!um_active && !u_valid && $urandom_range(0, 15) == 0) begin
        u_valid = 1; u_res = 32'h1234; u_tagi = UW'($urandom);
      end
      cycle();
    end
    run_until_quiet(200, "rand_drain");

`ifdef APU_DIV_DISP_TIMEOUT_EN
    // unit hangs: timeout error, then drain of the late valid
    hist.delete(); um_hang = 1; rv_cyc = -1; um_lat = 5;
    set_req(1, OP_DIV, 32'd50, 32'd5, 5'd9);
    n = 0;
    while (rv_cyc < 0 && n < 200) begin cycle(); n++; end
    chk("to_budget", (n >= 200), 0);
    chk("to_lat", rv_cyc - g_cyc, 64);
    chk("to_rdata", last_rdata, 32'hFFFF_FFFF);
    chk("to_rerr", last_rerr, 1);
    chk("to_rtag", last_rtag, 5'd9);
    set_req(0, OP_DIVU, 32'd9, 32'd3, 5'd1);
    repeat (10) cycle();
    chk("to_no_grant", hist.size(), 1);
    um_hang = 0; um_cnt = 1;
    run_until_quiet(50, "to_drain");
    chk("to_hist", hist.size(), 2);
    chk("to_next_core", hist[$], 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
